// File: rtl/shift_reg_univ_if.sv
// shift_reg_univ_if: data, control and status bundle for the universal shift register
interface shift_reg_univ_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic [WIDTH-1:0] d;
  logic [2:0]       mode;
  logic             start;
  logic [CNT_W-1:0] amt;
  logic             sin_l;
  logic             sin_r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic             busy;
  logic             done;
  modport master (output d, mode, start, amt, sin_l, sin_r, input q, qn, busy, done);
  modport slave  (input d, mode, start, amt, sin_l, sin_r, output q, qn, busy, done);
endinterface

// File: rtl/shift_reg_univ.sv
// shift_reg_univ: universal shift register with load, shift, rotate and multi-step rotate
module shift_reg_univ #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  shift_reg_univ_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] rotl, rotr;
  assign rotl     = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
  assign rotr     = {q_q[0], q_q[WIDTH-1:1]};
  assign bus.q    = q_q;
  assign bus.qn   = ~q_q;
  assign bus.busy = state_q == RUN;
  assign bus.done = done_q;
  // next state: single-edge ops in IDLE, one rotate per edge in RUN (dir 1 = right)
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    if (state_q == RUN) begin
      q_d   = dir_q ? rotr : rotl;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else begin
      case (bus.mode)
        3'b001:  q_d = bus.d;
        3'b010:  q_d = {q_q[WIDTH-2:0], bus.sin_r};
        3'b011:  q_d = {bus.sin_l, q_q[WIDTH-1:1]};
        3'b100:  q_d = rotl;
        3'b101:  q_d = rotr;
        3'b110, 3'b111: begin
          if (bus.start) begin
            if (bus.amt == '0) begin
              done_d = 1'b1;
            end else begin
              cnt_d   = bus.amt;
              dir_d   = bus.mode[0];
              state_d = RUN;
            end
          end
        end
        default: q_d = q_q;
      endcase
    end
  end
  // state register; reset clears everything at once and aborts a run without done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: doc/shift_reg_univ.md
SHIFT_REG_UNIV -- requirements
Module: shift_reg_univ

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits (>=2).
REQ-002 SHALL have parameter CNT_W, default 4, width of the multi-shift amount.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port d  input  WIDTH  parallel load data.
REQ-006 SHALL have port mode  input  3  operation select.
REQ-007 SHALL have port start  input  1  launches a multi-step rotate (modes 110/111).
REQ-008 SHALL have port amt  input  CNT_W  multi-step rotate count.
REQ-009 SHALL have port sin_l  input  1  serial input entering the MSB on a right shift.
REQ-010 SHALL have port sin_r  input  1  serial input entering the LSB on a left shift.
REQ-011 SHALL have port q  output  WIDTH  register contents.
REQ-012 SHALL have port qn  output  WIDTH  bitwise complement of q, always.
REQ-013 SHALL have port busy  output  1  multi-step rotate in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse at multi-step completion.

Function
REQ-015 SHALL update q only on rising clk edges; no level-sensitive (latch) storage.
REQ-016 SHALL be in state IDLE when busy=0 and in state RUN when busy=1.
REQ-017 In IDLE, SHALL apply at each edge: 000 hold; 001 q<=d; 010 q<={q[W-2:0],sin_r}; 011 q<={sin_l,q[W-1:1]}; 100 rotate left 1; 101 rotate right 1. start is ignored for these modes.
REQ-018 In IDLE with mode 110/111 and start=0, SHALL hold q.
REQ-019 In IDLE with mode 110/111, start=1 and amt=N>=1, SHALL latch N and direction (110 left, 111 right), set busy=1 and leave q unchanged at that edge.
REQ-020 In RUN, SHALL rotate q one position in the latched direction per edge, for exactly N edges.
REQ-021 On the edge performing the Nth rotate, SHALL set busy=0 and done=1.
REQ-022 done SHALL be 1 for exactly one cycle; an IDLE operation in that cycle SHALL be accepted normally.
REQ-023 In IDLE with mode 110/111, start=1 and amt=0, SHALL leave q unchanged, keep busy=0 and pulse done=1 for one cycle.
REQ-024 In RUN, SHALL ignore mode, d, start, amt, sin_l and sin_r.
REQ-025 amt >= WIDTH SHALL NOT be reduced; N rotates are performed, so the result equals rotation by N mod WIDTH after N cycles.
REQ-026 Multi-step latency: busy covers N cycles; total latency from start edge to done is N edges.

Reset
REQ-027 rst=1 SHALL immediately, without a clock edge, force q=0, qn=all ones, busy=0, done=0, state IDLE and count 0.
REQ-028 rst asserted during RUN SHALL abort the operation with no done pulse.
REQ-029 After rst deasserts, the first rising edge SHALL operate per REQ-017..REQ-023.

Verification (WIDTH=8, CNT_W=4)
REQ-030 Assert rst between edges -> q=00, qn=FF, busy=0, done=0 before next edge.
REQ-031 mode 001, d=A5 -> q=A5, qn=5A; then mode 000 for 3 edges -> q stays A5.
REQ-032 From q=81: mode 010 sin_r=0 -> 02; mode 100 -> 03; mode 011 sin_l=0 -> 40; mode 101 -> C0.
REQ-033 q=81, mode 110, start=1, amt=3 -> busy=1 for 3 cycles, then q=0C with busy=0 and done=1 for one cycle; start pulses during busy ignored.
REQ-034 q=81, mode 111, amt=10 -> q=60 after 10 cycles; amt=0 -> q=81, done pulses one cycle, busy stays 0.
REQ-035 Multi-rotate amt=5 with rst asserted after the 2nd rotate -> q=00, busy=0, no done; then mode 001 d=3C -> q=3C.
